// File: rtl/dbg_run_if.sv
// Board-side signal bundle of the Mock8080 debug/run-control unit.
// The board input drivers act as master; the controller is the slave.
interface dbg_run_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int TICK_W = 16
) ();

  logic              knob_pulse;
  logic              knob_dir;
  logic              btn_run;
  logic              btn_step;
  logic              btn_fast;
  logic [DATA_W-1:0] dbg_data_in;
  logic              cpu_tick;
  logic              running;
  logic              fast_mode;
  logic [ADDR_W-1:0] dbg_addr;
  logic              lcd_refresh;
  logic [TICK_W-1:0] tick_count;

  modport master (
    output knob_pulse, knob_dir, btn_run, btn_step, btn_fast, dbg_data_in,
    input  cpu_tick, running, fast_mode, dbg_addr, lcd_refresh, tick_count
  );

  modport slave (
    input  knob_pulse, knob_dir, btn_run, btn_step, btn_fast, dbg_data_in,
    output cpu_tick, running, fast_mode, dbg_addr, lcd_refresh, tick_count
  );

endinterface

// File: rtl/dbg_run_controller.sv
// Debug and run-control unit for the Mock8080 board: CPU tick enable with
// RUN/HALT/single-STEP, rotary-encoder-driven debug address with selectable
// step size, and an LCD refresh request whenever the shown address or data changes.
module dbg_run_controller #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 8,
  parameter int DIV_PERIOD = 100000000,
  parameter int FAST_STEP  = 16,
  parameter int TICK_W     = 16
) (
  input logic     qzt_clk,
  input logic     reset_n,
  dbg_run_if.slave bus
);

  localparam int                DIV_W    = (DIV_PERIOD > 2) ? $clog2(DIV_PERIOD) : 1;
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(DIV_PERIOD - 1);
  localparam logic [ADDR_W-1:0] FAST_INC = ADDR_W'(FAST_STEP);
  localparam logic [ADDR_W-1:0] SLOW_INC = ADDR_W'(1);

  typedef enum logic [1:0] {
    ST_HALT = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2
  } state_t;

  // Debug address update; ADDR_W-bit arithmetic gives the wrap in both directions.
  function automatic logic [ADDR_W-1:0] step_addr(
    input logic [ADDR_W-1:0] addr,
    input logic              dir,
    input logic              fast
  );
    logic [ADDR_W-1:0] inc;
    inc = fast ? FAST_INC : SLOW_INC;
    return dir ? (addr + inc) : (addr - inc);
  endfunction

  state_t              state;
  state_t              state_next;
  logic [DIV_W-1:0]    div_cnt;
  logic [DIV_W-1:0]    div_next;
  logic                tick_next;

  logic                btn_run_p0;
  logic                btn_step_p0;
  logic                btn_fast_p0;
  logic                run_edge;
  logic                step_edge;
  logic                fast_edge;

  logic                tick_p0;
  logic [TICK_W-1:0]   tick_cnt;
  logic                fast_p0;
  logic [ADDR_W-1:0]   addr_reg;

  logic [ADDR_W-1:0]   addr_p0;
  logic [DATA_W-1:0]   data_p0;
  logic                init_p0;
  logic                lcd_p0;
  logic                lcd_next;

  assign run_edge  = bus.btn_run  & ~btn_run_p0;
  assign step_edge = bus.btn_step & ~btn_step_p0;
  assign fast_edge = bus.btn_fast & ~btn_fast_p0;

  // Button history registers for rising-edge detection.
  always_ff @(posedge qzt_clk or negedge reset_n) begin
    if (!reset_n) begin
      btn_run_p0  <= 1'b0;
      btn_step_p0 <= 1'b0;
      btn_fast_p0 <= 1'b0;
    end else begin
      btn_run_p0  <= bus.btn_run;
      btn_step_p0 <= bus.btn_step;
      btn_fast_p0 <= bus.btn_fast;
    end
  end

  // FSM state, divider and the registered CPU tick.
  always_ff @(posedge qzt_clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_HALT;
      div_cnt <= '0;
      tick_p0 <= 1'b0;
    end else begin
      state   <= state_next;
      div_cnt <= div_next;
      tick_p0 <= tick_next;
    end
  end

  // Next state, divider and tick. btn_run beats btn_step in HALT; a run
  // edge leaving RUN suppresses a tick that would otherwise be due.
  always_comb begin
    state_next = state;
    div_next   = '0;
    tick_next  = 1'b0;
    case (state)
      ST_HALT: begin
        if (run_edge) begin
          state_next = ST_RUN;
        end else if (step_edge) begin
          state_next = ST_STEP;
          tick_next  = 1'b1;
        end
      end
      ST_RUN: begin
        if (run_edge) begin
          state_next = ST_HALT;
        end else if (div_cnt == DIV_LAST) begin
          tick_next = 1'b1;
        end else begin
          div_next = div_cnt + DIV_W'(1);
        end
      end
      ST_STEP: begin
        state_next = ST_HALT;
      end
      default: begin
        state_next = ST_HALT;
      end
    endcase
  end

  // Count of issued CPU ticks, free-wrapping.
  always_ff @(posedge qzt_clk or negedge reset_n) begin
    if (!reset_n) begin
      tick_cnt <= '0;
    end else if (tick_p0) begin
      tick_cnt <= tick_cnt + TICK_W'(1);
    end
  end

  // Fast-mode toggle and debug address; the step uses fast mode before any toggle.
  always_ff @(posedge qzt_clk or negedge reset_n) begin
    if (!reset_n) begin
      fast_p0  <= 1'b0;
      addr_reg <= '0;
    end else begin
      if (fast_edge) begin
        fast_p0 <= ~fast_p0;
      end
      if (bus.knob_pulse) begin
        addr_reg <= step_addr(addr_reg, bus.knob_dir, fast_p0);
      end
    end
  end

  assign lcd_next = (addr_reg != addr_p0) || (bus.dbg_data_in != data_p0) || !init_p0;

  // Watch registers and the registered LCD refresh request; init_p0 forces
  // one redraw on the first clock after reset.
  always_ff @(posedge qzt_clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_p0 <= '0;
      data_p0 <= '0;
      init_p0 <= 1'b0;
      lcd_p0  <= 1'b0;
    end else begin
      addr_p0 <= addr_reg;
      data_p0 <= bus.dbg_data_in;
      init_p0 <= 1'b1;
      lcd_p0  <= lcd_next;
    end
  end

  assign bus.cpu_tick    = tick_p0;
  assign bus.running     = (state == ST_RUN);
  assign bus.fast_mode   = fast_p0;
  assign bus.dbg_addr    = addr_reg;
  assign bus.lcd_refresh = lcd_p0;
  assign bus.tick_count  = tick_cnt;

endmodule
